instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
//  IF stage of the pipelined MIPS core. Holds the PC and drives it to the program ROM.
//  Computes the next PC from PC+4, a taken branch/jump redirect, or a hazard stall.
//  Latches the ROM's combinational instruction and PC+4 into the IF/ID pipeline register, which feeds decode.
//  Flags misaligned redirects and out-of-range fetches.
// PARAMETERS
//  DATA_WIDTH    32            width of PC, instruction, PC+4
//  MEMORY_DEPTH  32            words in program ROM; sets valid fetch window
//  TEXT_BASE     32'h00400000  byte address of ROM word 0; PC reset value
//  NOP_WORD      32'h00000000  bubble instruction (sll $0,$0,0)
// PORTS
//  clk             in   1           rising-edge clock
//  reset           in   1           synchronous, active-low reset
//  Stall           in   1           hazard unit: hold PC and IF/ID
//  Flush           in   1           squash IF/ID contents (bubble)
//  Redirect        in   1           taken branch/jump: load RedirectPC
//  RedirectPC      in   DATA_WIDTH  redirect target byte address
//  Instruction_i   in   DATA_WIDTH  ROM output for PC_o (combinational)
//  PC_o            out  DATA_WIDTH  current fetch address to ROM
//  IFID_Instr      out  DATA_WIDTH  registered instruction to decode
//  IFID_PCPlus4    out  DATA_WIDTH  registered PC+4 of that instruction
//  IFID_Valid      out  1           1 = IFID_Instr is a real fetched instruction
//  AlignFault      out  1           sticky: a redirect had RedirectPC[1:0]!=0
//  RangeFault      out  1           sticky: a fetch outside the ROM window occurred
// BEHAVIOUR
//  - All state updates on posedge clk. reset==0 has priority over every other input:
//    PC_o=TEXT_BASE, IFID_Instr=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0,
//    AlignFault=0, RangeFault=0.
//  - PC+4 is modulo 2^DATA_WIDTH. 0xFFFFFFFC+4 wraps to 0, which is then out of range.
//  - Next PC, in priority order:
//    Redirect ? {RedirectPC[W-1:2],2'b00} : Stall ? PC_o : PC_o+4.
//  - Redirect overrides Stall in the same cycle.
//  - InRange = (PC_o >= TEXT_BASE) && (PC_o - TEXT_BASE < 4*MEMORY_DEPTH).
//    Compute in DATA_WIDTH+1 bits so TEXT_BASE+4*MEMORY_DEPTH does not overflow.
//  - IF/ID register update, in priority order:
//    1. Flush|Redirect: Instr=NOP_WORD, PCPlus4=0, Valid=0.
//    2. Stall: hold all three.
//    3. !InRange: Instr=NOP_WORD, PCPlus4=PC_o+4, Valid=0.
//    4. else: Instr=Instruction_i, PCPlus4=PC_o+4, Valid=1.
//  - Latency: the instruction at PC_o in cycle n appears on IFID_* after the edge ending cycle n (1 cycle).
//  - Redirect penalty: the instruction fetched in the redirect cycle is squashed (one bubble).
//    The target appears on IFID two edges after Redirect is sampled.
//  - AlignFault is set on any edge sampling Redirect=1 with RedirectPC[1:0]!=0.
//    The PC loads the target with bits [1:0] cleared.
//  - RangeFault is set on any edge where !InRange, !Stall, !Flush and !Redirect.
//    Stalled, flushed or redirected cycles do not set it.
//  - Both fault flags are cleared only by reset. They do not stop fetch.
//  - Stall held for N cycles: PC_o and IFID_* stay constant for N edges, then resume unchanged.
//  - reset asserted mid-stall or mid-redirect: the reset values win on that edge.
//  - PC_o is a register output with no combinational path from any input.
// TESTING
//  1. Reset, then 4 free-run edges with ROM[i]=0x20080000+i:
//     PC_o 0x00400000->0x00400010; IFID_Instr 0x20080000..0x20080003; Valid=1; IFID_PCPlus4=0x00400004..
//  2. Stall=1 for 3 edges at PC_o=0x00400008:
//     PC_o and IFID_* frozen for 3 edges; next edge loads ROM[2], PC_o=0x0040000C.
//  3. Redirect=1, RedirectPC=0x00400040, Stall=1 in the same cycle:
//     PC_o=0x00400040, IFID_Valid=0; next edge IFID_Instr=ROM[16], Valid=1.
//  4. Redirect to 0x00400046:
//     PC_o=0x00400044, AlignFault=1 and stays 1 until reset=0.
//  5. Redirect to 0x00400080 (MEMORY_DEPTH=32):
//     IFID_Instr=0, Valid=0, RangeFault=1, PCPlus4=0x00400084; PC keeps advancing.
//  6. Flush=1 alone at PC_o=0x00400004:
//     IFID bubble (Valid=0), PC_o=0x00400008; reset=0 mid-run restores all reset values.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// instruction_fetch_stage : MIPS IF stage - PC register, next-PC select, IF/ID
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_stage #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    MEMORY_DEPTH = 32,
   parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h00400000,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD     = 32'h00000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Stall,
   input  logic                  Flush,
   input  logic                  Redirect,
   input  logic [DATA_WIDTH-1:0] RedirectPC,
   input  logic [DATA_WIDTH-1:0] Instruction_i,
   output logic [DATA_WIDTH-1:0] PC_o,
   output logic [DATA_WIDTH-1:0] IFID_Instr,
   output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
   output logic                  IFID_Valid,
   output logic                  AlignFault,
   output logic                  RangeFault
);

   localparam logic [DATA_WIDTH:0] c_WINDOW = (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);
   localparam logic [DATA_WIDTH:0] c_BASE   = {1'b0, TEXT_BASE};

   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] r_ifid_instr;
   logic [DATA_WIDTH-1:0] r_ifid_pc4;
   logic                  r_ifid_valid;
   logic                  r_align_fault;
   logic                  r_range_fault;

   logic [DATA_WIDTH-1:0] w_pc_plus4;
   logic [DATA_WIDTH-1:0] w_redirect_tgt;
   logic [DATA_WIDTH:0]   w_pc_ext;
   logic [DATA_WIDTH:0]   w_offset;
   logic                  w_in_range;
   logic                  w_squash;

   // Range check is one bit wider so TEXT_BASE + window never overflows.
   assign w_pc_ext       = {1'b0, r_pc};
   assign w_offset       = w_pc_ext - c_BASE;
   assign w_in_range     = (w_pc_ext >= c_BASE) && (w_offset < c_WINDOW);
   assign w_pc_plus4     = r_pc + DATA_WIDTH'(4);
   assign w_redirect_tgt = {RedirectPC[DATA_WIDTH-1:2], 2'b00};
   assign w_squash       = Flush | Redirect;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc          <= TEXT_BASE;
         r_ifid_instr  <= NOP_WORD;
         r_ifid_pc4    <= '0;
         r_ifid_valid  <= 1'b0;
         r_align_fault <= 1'b0;
         r_range_fault <= 1'b0;
      end else begin
         if (Redirect)
            r_pc <= w_redirect_tgt;
         else if (!Stall)
            r_pc <= w_pc_plus4;

         if (w_squash) begin
            r_ifid_instr <= NOP_WORD;
            r_ifid_pc4   <= '0;
            r_ifid_valid <= 1'b0;
         end else if (!Stall) begin
            r_ifid_instr <= w_in_range ? Instruction_i : NOP_WORD;
            r_ifid_pc4   <= w_pc_plus4;
            r_ifid_valid <= w_in_range;
         end

         if (Redirect && (RedirectPC[1:0] != 2'b00))
            r_align_fault <= 1'b1;
         if (!w_in_range && !Stall && !w_squash)
            r_range_fault <= 1'b1;
      end
   end

   assign PC_o         = r_pc;
   assign IFID_Instr   = r_ifid_instr;
   assign IFID_PCPlus4 = r_ifid_pc4;
   assign IFID_Valid   = r_ifid_valid;
   assign AlignFault   = r_align_fault;
   assign RangeFault   = r_range_fault;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// tb_instruction_fetch_stage : directed vector bench for the IF stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

   localparam logic [31:0] c_BASE = 32'h00400000;

   logic        clk;
   logic        reset;
   logic        Stall;
   logic        Flush;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic [31:0] Instruction_i;
   logic [31:0] PC_o;
   logic [31:0] IFID_Instr;
   logic [31:0] IFID_PCPlus4;
   logic        IFID_Valid;
   logic        AlignFault;
   logic        RangeFault;

   int checks = 0;
   int errors = 0;

   instruction_fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .Stall         (Stall),
      .Flush         (Flush),
      .Redirect      (Redirect),
      .RedirectPC    (RedirectPC),
      .Instruction_i (Instruction_i),
      .PC_o          (PC_o),
      .IFID_Instr    (IFID_Instr),
      .IFID_PCPlus4  (IFID_PCPlus4),
      .IFID_Valid    (IFID_Valid),
      .AlignFault    (AlignFault),
      .RangeFault    (RangeFault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program ROM: word i holds 0x20080000+i; outside the window it returns junk
   // so that any leak of the ROM output into IF/ID is visible.
   logic [31:0] w_rom_off;
   assign w_rom_off     = PC_o - c_BASE;
   assign Instruction_i = (PC_o >= c_BASE && w_rom_off < 32'd128)
                        ? (32'h20080000 + {2'b00, w_rom_off[31:2]}) : 32'hDEADBEEF;

   typedef struct {
      logic        rstn;
      logic        stall;
      logic        flush;
      logic        redir;
      logic [31:0] rpc;
      logic [31:0] epc;
      logic [31:0] einstr;
      logic [31:0] epc4;
      logic        ev;
      logic        eaf;
      logic        erf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input string tag);
      reset      = v.rstn;
      Stall      = v.stall;
      Flush      = v.flush;
      Redirect   = v.redir;
      RedirectPC = v.rpc;
      @(posedge clk);
      #1;
      chk({tag, ".PC_o"},         PC_o,                 v.epc);
      chk({tag, ".IFID_Instr"},   IFID_Instr,           v.einstr);
      chk({tag, ".IFID_PCPlus4"}, IFID_PCPlus4,         v.epc4);
      chk({tag, ".IFID_Valid"},   {31'd0, IFID_Valid},  {31'd0, v.ev});
      chk({tag, ".AlignFault"},   {31'd0, AlignFault},  {31'd0, v.eaf});
      chk({tag, ".RangeFault"},   {31'd0, RangeFault},  {31'd0, v.erf});
   endtask

   initial begin
      reset = 1'b0; Stall = 1'b0; Flush = 1'b0; Redirect = 1'b0; RedirectPC = '0;

      //              rstn stall flush redir rpc           pc            instr         pc4           v  af rf
      // free-run after reset
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400004, 32'h20080000, 32'h00400004, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400008, 32'h20080001, 32'h00400008, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0040000C, 32'h20080002, 32'h0040000C, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400010, 32'h20080003, 32'h00400010, 1'b1, 1'b0, 1'b0});
      // re-reset, advance to 0x00400008, stall 3 edges, resume
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400004, 32'h20080000, 32'h00400004, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400008, 32'h20080001, 32'h00400008, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h00400008, 32'h20080001, 32'h00400008, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h00400008, 32'h20080001, 32'h00400008, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h00400008, 32'h20080001, 32'h00400008, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0040000C, 32'h20080002, 32'h0040000C, 1'b1, 1'b0, 1'b0});
      // redirect together with stall: redirect wins, one bubble, then ROM[16]
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 32'h00400040, 32'h00400040, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400044, 32'h20080010, 32'h00400044, 1'b1, 1'b0, 1'b0});
      // misaligned redirect
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h00400046, 32'h00400044, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400048, 32'h20080011, 32'h00400048, 1'b1, 1'b1, 1'b0});
      // redirect to the first word past the window
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h00400080, 32'h00400080, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400084, 32'h00000000, 32'h00400084, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400088, 32'h00000000, 32'h00400088, 1'b0, 1'b1, 1'b1});
      // back into range, flush alone at 0x00400004
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h00400004, 32'h00400004, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h00400008, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0040000C, 32'h20080002, 32'h0040000C, 1'b1, 1'b1, 1'b1});
      // reset asserted mid-stall and mid-redirect wins
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 32'h00400046, 32'h00400000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400004, 32'h20080000, 32'h00400004, 1'b1, 1'b0, 1'b0});

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i], $sformatf("vec%0d", i));

      // Last ROM word is in range; stalled/flushed out-of-range cycles leave RangeFault clear.
      step('{1'b1, 1'b0, 1'b0, 1'b1, 32'h0040007C, 32'h0040007C, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0}, "edge_redir");
      step('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400080, 32'h2008001F, 32'h00400080, 1'b1, 1'b0, 1'b0}, "edge_last");
      step('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h00400080, 32'h2008001F, 32'h00400080, 1'b1, 1'b0, 1'b0}, "oor_stall");
      step('{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h00400084, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0}, "oor_flush");
      step('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400088, 32'h00000000, 32'h00400088, 1'b0, 1'b0, 1'b1}, "oor_free");

      // Below the window, and PC+4 wrapping to zero.
      step('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0}, "wrap_rst");
      step('{1'b1, 1'b0, 1'b0, 1'b1, 32'h003FFFFC, 32'h003FFFFC, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0}, "below_redir");
      step('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400000, 32'h00000000, 32'h00400000, 1'b0, 1'b0, 1'b1}, "below_free");
      step('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00400004, 32'h20080000, 32'h00400004, 1'b1, 1'b0, 1'b1}, "base_free");
      step('{1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b1}, "wrap_redir");
      step('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b1}, "wrap_top");
      step('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00000004, 32'h00000000, 32'h00000004, 1'b0, 1'b1, 1'b1}, "wrap_zero");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
